fxp_avg_engine: RTL

//  Hardware accelerator for the fixed-point average program. It runs a Start/Ack job: it reads N and N values
//  in Q(DW).(DW) format from byte-addressed data memory, then accumulates them. A sequential restoring divider

---
 rtl/fxp_avg_pkg.sv | 30 +++
 rtl/fxp_avg_engine_seq_divider.sv | 75 +++++++
 rtl/fxp_avg_engine.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fxp_avg_pkg.sv
// fxp_avg_pkg: shared types and address/width helpers for the fixed-point average engine.
// Operand i occupies two bytes after N: integer part first, then fraction part.
package fxp_avg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ARMED,
    RD_N,
    RD_HI,
    RD_LO,
    ACC,
    DIV,
    WR_HI,
    WR_LO,
    DONE
  } state_t;

  function automatic int sum_width(input int dw, input int cnt_w);
    return 2 * dw + cnt_w;
  endfunction

  function automatic int hi_off(input int idx);
    return 2 * idx + 1;
  endfunction

  function automatic int lo_off(input int idx);
    return 2 * idx + 2;
  endfunction

endpackage

// File: rtl/fxp_avg_engine_seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle, W cycles per divide.
// The first bit is produced on the start edge, so done_o pulses exactly W cycles after start_i.
module seq_divider #(
  parameter int W      = 24,
  parameter int DVSR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [W-1:0]      dividend_i,
  input  logic [DVSR_W-1:0] divisor_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [W-1:0]      quotient_o
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]      quo_q, quo_d, quo_src;
  logic [DVSR_W-1:0] rem_q, rem_d, rem_src;
  logic [DVSR_W:0]   shifted, trial;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d, step;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    step    = busy_q | start_i;
    quo_src = busy_q ? quo_q : dividend_i;
    rem_src = busy_q ? rem_q : '0;
    shifted = {rem_src, quo_src[W-1]};
    trial   = shifted - {1'b0, divisor_i};
    if (step) begin
      // A borrow out of the trial subtraction means the divisor did not fit: restore.
      quo_d = {quo_src[W-2:0], ~trial[DVSR_W]};
      rem_d = trial[DVSR_W] ? shifted[DVSR_W-1:0] : trial[DVSR_W-1:0];
      if (busy_q) begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end else begin
        cnt_d  = CW'(W - 1);
        busy_d = 1'b1;
      end
    end
  end

  // NOTE: registers take non-blocking updates so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/fxp_avg_engine.sv
// fxp_avg_engine: Start/Ack accelerator averaging N fixed-point values read from data memory.
// Define FXP_AVG_ROUND_EN for round-half-up, saturating results (one extra divide cycle).
module fxp_avg_engine
  import fxp_avg_pkg::*;
#(
  parameter int DW     = 8,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 9,
  parameter int BASE   = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Rd_En,
  input  logic [DW-1:0]     Mem_Rd_Data,
  output logic              Mem_Wr_En,
  output logic [DW-1:0]     Mem_Wr_Data
);

  localparam int SUM_W = sum_width(DW, CNT_W);
  localparam int RES_W = 2 * DW;
`ifdef FXP_AVG_ROUND_EN
  localparam int DIV_W  = SUM_W + 1;
  localparam int DVSR_W = CNT_W + 1;
`else
  localparam int DIV_W  = SUM_W;
  localparam int DVSR_W = CNT_W;
`endif

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [CNT_W-1:0]  n_q, n_d, idx_q, idx_d;
  logic [DW-1:0]     hi_q, hi_d;
  logic [SUM_W-1:0]  sum_q, sum_d;

  logic              ack_c, rd_en_c, wr_en_c, div_start, div_busy, div_done;
  logic [DIV_W-1:0]  div_dividend, div_quotient;
  logic [DVSR_W-1:0] div_divisor;
  logic [RES_W-1:0]  result;

`ifdef FXP_AVG_ROUND_EN
  // floor((2*sum + N) / (2N)) rounds half up without a separate correction step.
  assign div_dividend = {sum_q, 1'b0} + DIV_W'(n_q);
  assign div_divisor  = {n_q, 1'b0};
`else
  assign div_dividend = sum_q;
  assign div_divisor  = n_q;
`endif

  assign result = (n_q == '0)                     ? '0 :
                  (|div_quotient[DIV_W-1:RES_W])  ? '1 : div_quotient[RES_W-1:0];

  seq_divider #(
    .W      (DIV_W),
    .DVSR_W (DVSR_W)
  ) u_div (
    .clk        (Clk),
    .rst_n      (Reset),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (div_divisor),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quotient)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = 1'b0;
    n_d         = n_q;
    idx_d       = idx_q;
    hi_d        = hi_q;
    sum_d       = sum_q;
    ack_c       = 1'b0;
    rd_en_c     = 1'b0;
    wr_en_c     = 1'b0;
    div_start   = 1'b0;
    Mem_Addr    = '0;
    Mem_Wr_Data = '0;
    case (state_q)
      IDLE:  if (Start) state_d = ARMED;
      ARMED: if (!Start) state_d = RD_N;
      RD_N: begin
        if (!phase_q) begin
          rd_en_c  = 1'b1;
          Mem_Addr = ADDR_W'(BASE);
          phase_d  = 1'b1;
          sum_d    = '0;
          idx_d    = '0;
        end else begin
          n_d     = CNT_W'(Mem_Rd_Data);
          state_d = (CNT_W'(Mem_Rd_Data) == '0) ? WR_HI : RD_HI;
        end
      end
      RD_HI: begin
        if (!phase_q) begin
          rd_en_c  = 1'b1;
          Mem_Addr = ADDR_W'(BASE + hi_off(int'(idx_q)));
          phase_d  = 1'b1;
        end else begin
          hi_d    = Mem_Rd_Data;
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        rd_en_c  = 1'b1;
        Mem_Addr = ADDR_W'(BASE + lo_off(int'(idx_q)));
        state_d  = ACC;
      end
      ACC: begin
        // The low byte is captured straight off the read port as it is added.
        sum_d = sum_q + SUM_W'({hi_q, Mem_Rd_Data});
        if (idx_q == n_q - CNT_W'(1)) begin
          state_d = DIV;
        end else begin
          idx_d   = idx_q + CNT_W'(1);
          state_d = RD_HI;
        end
      end
      DIV: begin
        div_start = !div_busy && !div_done;
        if (div_done) state_d = WR_HI;
      end
      WR_HI: begin
        wr_en_c     = 1'b1;
        Mem_Addr    = ADDR_W'(BASE + hi_off(int'(n_q)));
        Mem_Wr_Data = result[RES_W-1:DW];
        state_d     = WR_LO;
      end
      WR_LO: begin
        wr_en_c     = 1'b1;
        Mem_Addr    = ADDR_W'(BASE + lo_off(int'(n_q)));
        Mem_Wr_Data = result[DW-1:0];
        state_d     = DONE;
      end
      DONE: begin
        ack_c = 1'b1;
        if (Start) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes and Ack are gated by Reset so an abort takes effect within the same cycle.
  assign Ack       = ack_c & Reset;
  assign Mem_Rd_En = rd_en_c & Reset;
  assign Mem_Wr_En = wr_en_c & Reset;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      n_q     <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      sum_q   <= sum_d;
    end
  end

endmodule
